packet_stream_gen: RTL and testbench

- Synthesizable, parametrised packet source for the InBus interface (Valid/Sop/Eop/Mod/Data); used as a stimulus driver in front of packet_parser_top and any other InBus consumer.
- Generates a programmed number of packets with fixed or LFSR-random lengths, a deterministic payload, a configurable inter-packet gap, and downstream backpressure.
- Emits a per-packet length/ID record so a checker can predict expected field values.

---
 rtl/packet_stream_gen.sv | 161 ++++++++++++++++
 tb/tb_packet_stream_gen.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_stream_gen.sv
// packet_stream_gen: parametrised InBus packet source.
// Sends a programmed number of packets (fixed or LFSR-random length) with an
// incrementing-byte payload, an inter-packet gap and Ready backpressure, and
// reports each packet's length/ID when its Sop beat is accepted.
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   start               run request, honoured only when idle
//   cfg_num_pkts        packets per run (0 = endless)
//   cfg_fixed_len_en    1 = fixed length cfg_fixed_len (0 treated as 1)
//   InBus_Ready         downstream accepts current beat
//   InBus_*             Valid/Sop/Eop/Mod/Data beat outputs
//   busy, done          run in progress / one-cycle completion pulse
//   pkt_info_*          per-packet length/ID pulse at Sop acceptance
module packet_stream_gen #(
  parameter int          DATA_WIDTH = 64,
  parameter int          LEN_MIN    = 10,
  parameter int          LEN_MAX    = 110,
  parameter int          IPG        = 2,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic                            start,
  input  logic [15:0]                     cfg_num_pkts,
  input  logic                            cfg_fixed_len_en,
  input  logic [15:0]                     cfg_fixed_len,
  input  logic                            InBus_Ready,
  output logic                            InBus_DataValid,
  output logic                            InBus_DataSop,
  output logic                            InBus_DataEop,
  output logic [$clog2(DATA_WIDTH/8)-1:0] InBus_Mod,
  output logic [DATA_WIDTH-1:0]           InBus_Data,
  output logic                            busy,
  output logic                            done,
  output logic                            pkt_info_valid,
  output logic [15:0]                     pkt_info_len,
  output logic [15:0]                     pkt_info_id
);

  localparam int          BPB       = DATA_WIDTH / 8;
  localparam int          MOD_W     = $clog2(BPB);
  localparam int          LEN_RANGE = LEN_MAX - LEN_MIN + 1;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  // The LEN cycle itself is one idle cycle, so GAP only supplies the rest.
  localparam int          GAP_W     = (IPG > 2) ? $clog2(IPG - 1) : 1;
  localparam int          GAP_LAST  = (IPG > 1) ? IPG - 2 : 0;

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_SEND, S_GAP, S_DONE} state_t;

  state_t           state, state_n;
  logic [15:0]      num_q;
  logic             fixed_en_q;
  logic [15:0]      fixed_len_q;
  logic [31:0]      lfsr;
  logic [15:0]      pkt_id;
  logic [15:0]      len_q;
  logic [15:0]      byte_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             xfer;
  logic             eop_hit;
  logic             last_pkt;
  logic [16:0]      lane_b;

  function automatic logic [15:0] calc_len(input logic        fixed_en,
                                           input logic [15:0] fixed_len,
                                           input logic [31:0] lfsr_v);
    logic [31:0] r;
    r = 32'(LEN_MIN) + (32'(lfsr_v[15:0]) % 32'(LEN_RANGE));
    if (fixed_en) calc_len = (fixed_len == 16'd0) ? 16'd1 : fixed_len;
    else          calc_len = r[15:0];
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    lfsr_step = v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

  assign xfer     = InBus_DataValid && InBus_Ready;
  assign eop_hit  = ({1'b0, byte_cnt} + 17'(BPB)) >= {1'b0, len_q};
  assign last_pkt = (num_q != 16'd0) && (pkt_id == num_q - 16'd1);

  // Beat outputs are decoded straight from held state, so they stay stable
  // while Ready is low and fall to zero whenever the FSM leaves SEND.
  assign InBus_DataValid = (state == S_SEND);
  assign InBus_DataSop   = InBus_DataValid && (byte_cnt == 16'd0);
  assign InBus_DataEop   = InBus_DataValid && eop_hit;
  assign InBus_Mod       = InBus_DataEop ? len_q[MOD_W-1:0] : '0;
  assign busy            = (state == S_LEN) || (state == S_SEND) || (state == S_GAP);
  assign done            = (state == S_DONE);
  assign pkt_info_valid  = xfer && InBus_DataSop;
  assign pkt_info_len    = pkt_info_valid ? len_q : 16'd0;
  assign pkt_info_id     = pkt_info_valid ? pkt_id : 16'd0;

  always_comb begin
    InBus_Data = '0;
    lane_b     = '0;
    for (int i = 0; i < BPB; i++) begin
      lane_b = {1'b0, byte_cnt} + 17'(i);
      if (InBus_DataValid && (lane_b < {1'b0, len_q}))
        InBus_Data[8*i +: 8] = pkt_id[7:0] + lane_b[7:0];
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = S_LEN;
      S_LEN:  state_n = S_SEND;
      S_SEND: begin
        if (xfer && eop_hit) begin
          if (last_pkt)     state_n = S_DONE;
          else if (IPG > 1) state_n = S_GAP;
          else              state_n = S_LEN;
        end
      end
      S_GAP:  if (gap_cnt == GAP_W'(GAP_LAST)) state_n = S_LEN;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= S_IDLE;
      num_q       <= 16'd0;
      fixed_en_q  <= 1'b0;
      fixed_len_q <= 16'd0;
      lfsr        <= LFSR_SEED;
      pkt_id      <= 16'd0;
      len_q       <= 16'd0;
      byte_cnt    <= 16'd0;
      gap_cnt     <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (start) begin
            num_q       <= cfg_num_pkts;
            fixed_en_q  <= cfg_fixed_len_en;
            fixed_len_q <= cfg_fixed_len;
            pkt_id      <= 16'd0;
          end
        end
        S_LEN: begin
          len_q    <= calc_len(fixed_en_q, fixed_len_q, lfsr);
          lfsr     <= lfsr_step(lfsr);
          byte_cnt <= 16'd0;
          gap_cnt  <= '0;
        end
        S_SEND: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 16'(BPB);
            if (eop_hit) pkt_id <= pkt_id + 16'd1;
          end
        end
        S_GAP: gap_cnt <= gap_cnt + GAP_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_stream_gen.sv
// Scoreboard bench for packet_stream_gen (DATA_WIDTH=64, IPG=2, LEN 10..110).
module tb_packet_stream_gen;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        start;
  logic [15:0] cfg_num_pkts;
  logic        cfg_fixed_len_en;
  logic [15:0] cfg_fixed_len;
  logic        InBus_Ready;
  logic        InBus_DataValid, InBus_DataSop, InBus_DataEop;
  logic [2:0]  InBus_Mod;
  logic [63:0] InBus_Data;
  logic        busy, done;
  logic        pkt_info_valid;
  logic [15:0] pkt_info_len, pkt_info_id;

  packet_stream_gen dut (
    .Clk(Clk), .Rst(Rst), .start(start), .cfg_num_pkts(cfg_num_pkts),
    .cfg_fixed_len_en(cfg_fixed_len_en), .cfg_fixed_len(cfg_fixed_len),
    .InBus_Ready(InBus_Ready), .InBus_DataValid(InBus_DataValid),
    .InBus_DataSop(InBus_DataSop), .InBus_DataEop(InBus_DataEop),
    .InBus_Mod(InBus_Mod), .InBus_Data(InBus_Data), .busy(busy), .done(done),
    .pkt_info_valid(pkt_info_valid), .pkt_info_len(pkt_info_len),
    .pkt_info_id(pkt_info_id)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        sop, eop;
    logic [2:0]  mod;
    logic [63:0] data;
    logic        last, gapck, rng;
  } beat_t;

  typedef struct {
    logic [15:0] len, id;
  } info_t;

  beat_t exp_beats[$];
  info_t exp_info[$];
  int total = 0;
  int bad = 0;
  int xfers = 0;
  logic done_pend = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic push_beat(input logic sop, input logic eop, input logic [2:0] mod,
                           input logic [63:0] data, input logic last, input logic gapck);
    beat_t b;
    b.sop = sop; b.eop = eop; b.mod = mod; b.data = data;
    b.last = last; b.gapck = gapck; b.rng = 1'b0;
    exp_beats.push_back(b);
  endtask

  task automatic push_info(input int len, input int id);
    info_t i;
    i.len = 16'(len); i.id = 16'(id);
    exp_info.push_back(i);
  endtask

  // Expected beats of one packet from the payload rule; maxb truncates.
  task automatic push_pkt(input int len, input int id, input logic last,
                          input logic rng, input int maxb);
    int nb;
    beat_t b;
    nb = (len + 7) / 8;
    for (int k = 0; k < nb && k < maxb; k++) begin
      b.data = '0;
      for (int i = 0; i < 8; i++)
        if (k * 8 + i < len) b.data[8*i +: 8] = 8'((id + k * 8 + i) % 256);
      b.sop = (k == 0);
      b.eop = (k == nb - 1);
      b.mod = b.eop ? 3'(len % 8) : 3'd0;
      b.last = last && b.eop;
      b.gapck = 1'b0;
      b.rng = rng;
      exp_beats.push_back(b);
    end
    push_info(len, id);
  endtask

  function automatic logic [31:0] lstep(input logic [31:0] v);
    lstep = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  // Monitor: pops the scoreboard on each accepted beat.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [4:0]  prev_ctl;
  int          idle_run = 0;
  always @(negedge Clk) begin
    beat_t e;
    info_t inf;
    if (Rst) begin
      prev_stall = 1'b0;
      done_pend  = 1'b0;
      idle_run   = 0;
    end else begin
      if (done_pend) begin
        chk("done_pulse", 64'(done), 1);
        chk("busy_clear_at_done", 64'(busy), 0);
        done_pend = 1'b0;
      end else if (done) begin
        chk("done_spurious", 64'(done), 0);
      end
      if (prev_stall) begin
        chk("stall_valid", 64'(InBus_DataValid), 1);
        chk("stall_data", InBus_Data, prev_data);
        chk("stall_ctl", 64'({InBus_DataSop, InBus_DataEop, InBus_Mod}), 64'(prev_ctl));
      end
      if (!InBus_DataValid) idle_run++;
      if (InBus_DataValid && InBus_Ready) begin
        xfers++;
        chk("beat_expected", 64'(exp_beats.size() != 0), 1);
        if (exp_beats.size() != 0) begin
          e = exp_beats.pop_front();
          chk("beat_sop", 64'(InBus_DataSop), 64'(e.sop));
          chk("beat_eop", 64'(InBus_DataEop), 64'(e.eop));
          chk("beat_mod", 64'(InBus_Mod), 64'(e.mod));
          chk("beat_data", InBus_Data, e.data);
          if (e.sop) begin
            if (e.gapck) chk("ipg_idle_cycles", 64'(idle_run), 2);
            chk("info_valid", 64'(pkt_info_valid), 1);
            if (exp_info.size() != 0) begin
              inf = exp_info.pop_front();
              chk("info_len", 64'(pkt_info_len), 64'(inf.len));
              chk("info_id", 64'(pkt_info_id), 64'(inf.id));
            end
            if (e.rng)
              chk("len_in_range", 64'(pkt_info_len >= 16'd10 && pkt_info_len <= 16'd110), 1);
          end else if (pkt_info_valid) begin
            chk("info_spurious", 64'(pkt_info_valid), 0);
          end
          if (e.last) done_pend = 1'b1;
        end
        idle_run = 0;
      end
      prev_stall = InBus_DataValid && !InBus_Ready;
      prev_data  = InBus_Data;
      prev_ctl   = {InBus_DataSop, InBus_DataEop, InBus_Mod};
    end
  end

  task automatic check_quiet(input string tag);
    chk({tag, "_valid"}, 64'(InBus_DataValid), 0);
    chk({tag, "_sop"}, 64'(InBus_DataSop), 0);
    chk({tag, "_eop"}, 64'(InBus_DataEop), 0);
    chk({tag, "_mod"}, 64'(InBus_Mod), 0);
    chk({tag, "_data"}, InBus_Data, 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_info"}, 64'({pkt_info_valid, pkt_info_len, pkt_info_id}), 0);
  endtask

  task automatic do_reset();
    @(posedge Clk); #1;
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
  endtask

  task automatic start_run(input int num, input logic fen, input int flen);
    @(posedge Clk); #1;
    cfg_num_pkts = 16'(num);
    cfg_fixed_len_en = fen;
    cfg_fixed_len = 16'(flen);
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input logic toggle, input int budget);
    int  n;
    logic [3:0] pat;
    pat = 4'b1001;
    n = 0;
    while (n < budget && (exp_beats.size() != 0 || busy || done_pend)) begin
      InBus_Ready = toggle ? pat[3 - (n % 4)] : 1'b1;
      @(posedge Clk); #1;
      n++;
    end
    InBus_Ready = 1'b1;
    chk({tag, "_finished_in_budget"}, 64'(n < budget), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lf;
    int x0;
    int len_m;
    Rst = 1'b1; start = 1'b0; cfg_num_pkts = '0; cfg_fixed_len_en = 1'b0;
    cfg_fixed_len = '0; InBus_Ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    check_quiet("reset");

    // 20-byte fixed packet: three beats, Mod 4, hand-written payload.
    push_info(20, 0);
    push_beat(1, 0, 3'd0, 64'h0706050403020100, 0, 0);
    push_beat(0, 0, 3'd0, 64'h0f0e0d0c0b0a0908, 0, 0);
    push_beat(0, 1, 3'd4, 64'h0000000013121110, 1, 0);
    start_run(1, 1, 20);
    wait_idle("len20", 0, 100);

    // Three 8-byte packets with the inter-packet gap.
    push_info(8, 0); push_beat(1, 1, 3'd0, 64'h0706050403020100, 0, 0);
    push_info(8, 1); push_beat(1, 1, 3'd0, 64'h0807060504030201, 0, 1);
    push_info(8, 2); push_beat(1, 1, 3'd0, 64'h0908070605040302, 1, 1);
    start_run(3, 1, 8);
    wait_idle("ipg", 0, 100);

    // 40-byte packet under Ready pattern 1,0,0,1.
    x0 = xfers;
    push_pkt(40, 0, 1, 0, 99);
    start_run(1, 1, 40);
    wait_idle("stall", 1, 200);
    chk("stall_beat_count", 64'(xfers - x0), 5);

    // Random lengths twice from the same seed.
    for (int run = 0; run < 2; run++) begin
      do_reset();
      lf = 32'hACE1_0001;
      for (int k = 0; k < 8; k++) begin
        len_m = 10 + int'(lf[15:0]) % 101;
        lf = lstep(lf);
        push_pkt(len_m, k, k == 7, 1, 99);
      end
      start_run(8, 0, 0);
      wait_idle("random", 0, 800);
    end

    // Reset while beat 2 of a 40-byte packet is on the bus.
    do_reset();
    push_pkt(40, 0, 0, 0, 2);
    start_run(1, 1, 40);
    x0 = xfers;
    for (int k = 0; k < 50 && (xfers - x0) < 2; k++) begin
      @(posedge Clk); #1;
    end
    chk("abort_two_beats_sent", 64'(xfers - x0), 2);
    InBus_Ready = 1'b0;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    InBus_Ready = 1'b1;
    @(negedge Clk);
    check_quiet("abort");
    chk("abort_queue_drained", 64'(exp_beats.size()), 0);
    push_pkt(12, 0, 1, 0, 99);
    start_run(1, 1, 12);
    wait_idle("after_abort", 0, 100);

    // Zero fixed length becomes 1 byte; starts while busy are ignored.
    x0 = xfers;
    push_pkt(1, 0, 0, 0, 99);
    push_pkt(1, 1, 0, 0, 99);
    push_pkt(1, 2, 1, 0, 99);
    start_run(3, 1, 0);
    start_run(5, 1, 9);
    repeat (2) @(posedge Clk);
    #1;
    start_run(5, 1, 9);
    cfg_num_pkts = 16'd0;
    wait_idle("len0", 0, 100);
    repeat (10) @(posedge Clk);
    #1;
    chk("len0_total_pkts", 64'(xfers - x0), 3);
    chk("len0_queue_empty", 64'(exp_beats.size()), 0);
    chk("len0_idle_busy", 64'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
